// File: rtl/adder.sv
// 32-bit two-operand adder built from 4-bit carry-lookahead groups, with
// the group carry rippled from one group to the next. The sum and its flags
// are purely combinational. A registered shadow copy of the result and
// flags feeds debug/trace taps.

// One 4-bit carry-lookahead group: the carries inside the group come from
// generate/propagate terms, and the carry-out goes to the next group.
module adder_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Flattened lookahead: each carry depends only on g/p and the group carry-in.
  always_comb begin
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);
  end

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] out_q,
  output logic             carry_q,
  output logic             ovf_q
);
  localparam int NGRP = WIDTH / 4;

  logic [NGRP:0]          gc;
  logic [NGRP-1:0][3:0]   grp_sum;

  assign gc[0] = 1'b0;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    adder_cla4 u_grp (
      .a_i (input1[4*gi +: 4]),
      .b_i (input2[4*gi +: 4]),
      .c_i (gc[gi]),
      .s_o (grp_sum[gi]),
      .c_o (gc[gi+1])
    );
  end

  assign out      = grp_sum;
  assign carry    = gc[NGRP];
  // Signed overflow: both operands have the same sign and the result's sign differs from it.
  assign overflow = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                    (out[WIDTH-1] != input1[WIDTH-1]);
  assign zero     = ~|out;

  logic [WIDTH-1:0] out_d;
  logic             carry_d, ovf_d;

  assign out_d   = out;
  assign carry_d = carry;
  assign ovf_d   = overflow;

  // Shadow copy for trace taps: cleared at once by the async reset, otherwise captures each rising clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_adder.sv
// Randomized bench for adder. The expected values come from a wide-integer
// reference model, and the bench also exercises the shadow-stage reset behaviour.
module tb_adder;
  localparam int W = 32;

  logic         clk, rst_n, clk_run;
  logic [W-1:0] a, b;
  logic [W-1:0] out, out_q;
  logic         carry, overflow, zero, carry_q, ovf_q;

  int total = 0;
  int bad   = 0;

  adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .input1   (a),
    .input2   (b),
    .out      (out),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .out_q    (out_q),
    .carry_q  (carry_q),
    .ovf_q    (ovf_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model, result packed as {ovf, zero, carry, sum}.
  function automatic logic [W+2:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned us;
    longint          ss;
    logic            ov;
    us = longint'(x) + longint'(y);
    ss = longint'($signed(x)) + longint'($signed(y));
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {ov, (us[W-1:0] == '0), us[W], us[W-1:0]};
  endfunction

  task automatic chk_comb(input string tag);
    logic [W+2:0] r;
    r = ref_add(a, b);
    chk({tag, ".out"}, 64'(out), 64'(r[W-1:0]));
    chk({tag, ".c"},   64'(carry), 64'(r[W]));
    chk({tag, ".z"},   64'(zero), 64'(r[W+1]));
    chk({tag, ".v"},   64'(overflow), 64'(r[W+2]));
  endtask

  logic [W-1:0] seq_b [5] = '{32'd10000, 32'd30000, 32'd50000, 32'd170000, 32'd2000000};
  logic [W-1:0] seq_a [5] = '{32'd10000, 32'd10000, 32'd10000, 32'd10000, 32'd10000000};
  logic [W-1:0] seq_s [5] = '{32'd20000, 32'd40000, 32'd60000, 32'd180000, 32'd12000000};

  initial begin
    logic [W+2:0] r;
    clk_run = 1'b0;
    rst_n   = 1'b0;
    a = '0; b = '0;
    #3;
    chk("rst.out_q", 64'(out_q), 64'd0);
    chk("rst.carry_q", 64'(carry_q), 64'd0);
    chk("rst.ovf_q", 64'(ovf_q), 64'd0);

    // Combinational path with clk idle and reset asserted
    a = 32'd10000; b = 32'd20000; #1;
    chk("idle.out", 64'(out), 64'd30000);
    chk("idle.c", 64'(carry), 64'd0);
    chk("idle.v", 64'(overflow), 64'd0);
    chk("idle.z", 64'(zero), 64'd0);
    chk_comb("idle");

    for (int i = 0; i < 5; i++) begin
      a = seq_a[i]; b = seq_b[i];
      #9;
      chk($sformatf("seq%0d", i), 64'(out), 64'(seq_s[i]));
      #1;
    end

    a = 32'hFFFFFFFF; b = 32'h1; #1;
    chk("wrap.out", 64'(out), 64'd0);
    chk("wrap.c", 64'(carry), 64'd1);
    chk("wrap.z", 64'(zero), 64'd1);
    chk("wrap.v", 64'(overflow), 64'd0);

    a = 32'h7FFFFFFF; b = 32'h1; #1;
    chk("ovf.out", 64'(out), 64'h80000000);
    chk("ovf.v", 64'(overflow), 64'd1);
    chk("ovf.c", 64'(carry), 64'd0);
    a = 32'h80000000; b = 32'h80000000; #1;
    chk_comb("negovf");

    // Shadow stage
    rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    chk("sh.out_q", 64'(out_q), 64'd12);
    #2;
    rst_n = 1'b0; #1;
    chk("sh.rst_out_q", 64'(out_q), 64'd0);
    chk("sh.rst_out", 64'(out), 64'd12);
    @(posedge clk); #1;
    chk("sh.hold_q", 64'(out_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sh.rel_q", 64'(out_q), 64'd0);
    @(posedge clk); #1;
    chk("sh.cap_q", 64'(out_q), 64'd12);

    // Random operands: combinational check, then one-cycle shadow capture
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      case (i % 8)
        0: begin a = $urandom; b = ~a + W'($urandom_range(0, 2)); end
        1: begin a = 32'h7FFFFFFF - W'($urandom_range(0, 3)); b = W'($urandom_range(0, 7)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      #1;
      chk_comb("rnd");
      r = ref_add(a, b);
      @(posedge clk); #1;
      chk("rnd.out_q", 64'(out_q), 64'(r[W-1:0]));
      chk("rnd.carry_q", 64'(carry_q), 64'(r[W]));
      chk("rnd.ovf_q", 64'(ovf_q), 64'(r[W+2]));
    end

    clk_run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
